cplx_delay_line: RTL and testbench

CPLX_DELAY_LINE -- requirements
Module: cplx_delay_line

---
 rtl/cplx_delay_line.sv | 112 +++++++++++
 tb/tb_cplx_delay_line.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cplx_delay_line.sv
// Complex-sample delay line with runtime-selectable length.
// A circular buffer holds the last L accepted samples. Each accepted edge
// reads the oldest slot and overwrites it in place, which gives a latency of
// exactly L enabled edges. A flush or a length change empties the line, and
// outputs stay at zero until the line has been refilled.
module cplx_delay_line #(
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_DEPTH = 30,
  parameter int unsigned LW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          out_valid,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_img,
  output logic          primed,
  output logic          len_err
);

  localparam int unsigned   PW   = $clog2(MAX_DEPTH);
  localparam logic [LW-1:0] MAXL = LW'(MAX_DEPTH);

  // Sample storage; contents need no reset because the valid tags, the fill
  // count and the output gating keep stale words from ever being emitted.
  logic [DW-1:0]        mem_re  [MAX_DEPTH];
  logic [DW-1:0]        mem_img [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vmem;

  logic [PW-1:0] ptr;
  logic [LW-1:0] act_len;
  logic [LW-1:0] fill;
  logic          started;

  logic          len_ok_c;
  logic [LW-1:0] eff_len_c;
  logic          len_chg_c;
  logic          clear_c;
  logic          accept_c;
  logic [PW-1:0] ptr_nxt_c;
  logic [LW-1:0] fill_nxt_c;

  // Length legality, change detection, accept qualification, next pointer/fill
  always_comb begin
    len_ok_c   = (len != '0) && (len <= MAXL);
    eff_len_c  = len_ok_c ? len : MAXL;
    len_chg_c  = !started || (eff_len_c != act_len);
    clear_c    = flush || len_chg_c;
    accept_c   = en && !clear_c;
    ptr_nxt_c  = (ptr == PW'(act_len - LW'(1))) ? '0 : ptr + PW'(1);
    fill_nxt_c = (fill == act_len) ? fill : fill + LW'(1);
  end

  // Data words: write the incoming sample into the slot being read out
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_re[ptr]  <= in_re;
      mem_img[ptr] <= in_img;
    end
  end

  // Control state, valid tags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      fill      <= '0;
      act_len   <= MAXL;
      started   <= 1'b0;
      vmem      <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_img   <= '0;
      primed    <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      started <= 1'b1;
      len_err <= !len_ok_c;
      if (len_chg_c) begin
        act_len <= eff_len_c;
      end
      if (clear_c) begin
        ptr       <= '0;
        fill      <= '0;
        vmem      <= '0;
        out_valid <= 1'b0;
        out_re    <= '0;
        out_img   <= '0;
        primed    <= 1'b0;
      end else if (accept_c) begin
        vmem[ptr] <= in_valid;
        ptr       <= ptr_nxt_c;
        fill      <= fill_nxt_c;
        primed    <= (fill_nxt_c == act_len);
        if (primed) begin
          out_valid <= vmem[ptr];
          out_re    <= mem_re[ptr];
          out_img   <= mem_img[ptr];
        end else begin
          out_valid <= 1'b0;
          out_re    <= '0;
          out_img   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cplx_delay_line.sv
// Directed-plus-random bench for cplx_delay_line against a queue-based model.
module tb_cplx_delay_line;

  localparam int unsigned DW   = 32;
  localparam int unsigned MAXD = 30;
  localparam int unsigned LW   = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          flush;
  logic [LW-1:0] len;
  logic          in_valid;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_img;
  logic          out_valid;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_img;
  logic          primed;
  logic          len_err;

  int errors = 0;
  int checks = 0;

  cplx_delay_line #(.DW(DW), .MAX_DEPTH(MAXD), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .len(len),
    .in_valid(in_valid), .in_re(in_re), .in_img(in_img),
    .out_valid(out_valid), .out_re(out_re), .out_img(out_img),
    .primed(primed), .len_err(len_err)
  );

  always #5 clk = ~clk;

  // Reference model: the line holds the accepted samples since the last clear;
  // after the (L+1)-th one the oldest is emitted, i.e. L edges of latency.
  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] img;
    logic          v;
  } smp_t;

  smp_t          q[$];
  int unsigned   m_act;
  bit            m_started;
  logic [DW-1:0] e_re, e_img;
  logic          e_v, e_primed, e_err;

  task automatic model_reset();
    q.delete();
    m_act = MAXD; m_started = 0;
    e_re = '0; e_img = '0; e_v = 1'b0; e_primed = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic f, input logic [LW-1:0] l,
                            input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i);
    bit ok, chg;
    int unsigned eff;
    smp_t s;
    ok  = (l != 0) && (int'(l) <= int'(MAXD));
    eff = ok ? int'(l) : MAXD;
    e_err = !ok;
    chg = !m_started || (eff != m_act);
    m_started = 1;
    if (chg) m_act = eff;
    if (f || chg) begin
      q.delete();
      e_re = '0; e_img = '0; e_v = 1'b0; e_primed = 1'b0;
    end else if (e) begin
      s.re = r; s.img = i; s.v = v;
      q.push_back(s);
      if (q.size() > int'(m_act) + 1) void'(q.pop_front());
      if (q.size() == int'(m_act) + 1) begin
        e_re = q[0].re; e_img = q[0].img; e_v = q[0].v;
      end else begin
        e_re = '0; e_img = '0; e_v = 1'b0;
      end
      e_primed = (q.size() >= int'(m_act));
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_re"},    64'(out_re),    64'(e_re));
    chk({tag, ".out_img"},   64'(out_img),   64'(e_img));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(e_v));
    chk({tag, ".primed"},    64'(primed),    64'(e_primed));
    chk({tag, ".len_err"},   64'(len_err),   64'(e_err));
  endtask

  // One clock: drive inputs, step model on the edge, compare 1 ns later
  task automatic cyc(input string tag, input logic e, input logic f, input logic [LW-1:0] l,
                     input logic v, input logic [DW-1:0] r, input logic [DW-1:0] i);
    en = e; flush = f; len = l; in_valid = v; in_re = r; in_img = i;
    @(posedge clk);
    model_step(e, f, l, v, r, i);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic rnd(input string tag, input logic e, input logic [LW-1:0] l);
    cyc(tag, e, 1'b0, l, 1'($urandom_range(0, 1)), $urandom(), $urandom());
  endtask

  logic [LW-1:0] lens [6];

  initial begin
    lens[0] = 5'd1; lens[1] = 5'd2; lens[2] = 5'd7;
    lens[3] = 5'd30; lens[4] = 5'd0; lens[5] = 5'd31;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; len = 5'd30;
    in_valid = 1'b0; in_re = '0; in_img = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // L=30 ramp: first edge loads the length, then n=1..40
    cyc("ld30", 1'b0, 1'b0, 5'd30, 1'b0, '0, '0);
    for (int n = 1; n <= 40; n++) begin
      cyc("ramp30", 1'b1, 1'b0, 5'd30, 1'b1, DW'(n), DW'(-n));
      if (n == 30) chk("ramp30.primed_at_30", 64'(primed), 64'd1);
      if (n == 31) chk("ramp30.first_out", 64'(out_re), 64'd1);
    end

    // L=5 with en toggling
    cyc("ld5", 1'b1, 1'b0, 5'd5, 1'b1, 32'hdead, 32'hbeef);
    for (int n = 1; n <= 30; n++)
      cyc("tog5", 1'(n % 2), 1'b0, 5'd5, 1'b1, DW'(n), DW'(100 + n));

    // L=8 with flush at sample 12
    cyc("ld8", 1'b1, 1'b0, 5'd8, 1'b1, '0, '0);
    for (int n = 1; n <= 30; n++)
      cyc("flush8", 1'b1, 1'(n == 12), 5'd8, 1'($urandom_range(0, 1)), DW'(n), $urandom());

    // Length change 8 -> 3 mid-stream
    for (int n = 1; n <= 15; n++) rnd("len3", 1'b1, 5'd3);

    // Illegal lengths clamp to MAX_DEPTH, then a legal one
    for (int n = 0; n < 40; n++) rnd("len0", 1'b1, 5'd0);
    for (int n = 0; n < 40; n++) rnd("len31", 1'b1, 5'd31);
    for (int n = 0; n < 10; n++) rnd("len4", 1'b1, 5'd4);

    // Random traffic with occasional flushes and length changes
    begin
      logic [LW-1:0] cur;
      cur = 5'd7;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 50) == 0) cur = lens[$urandom_range(0, 5)];
        cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0), cur,
            1'($urandom_range(0, 1)), $urandom(), $urandom());
      end
    end

    // Asynchronous reset between edges mid-stream
    for (int n = 0; n < 10; n++) rnd("pre_rst", 1'b1, 5'd4);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    #1 rst_n = 1'b1;
    for (int n = 0; n < 20; n++) rnd("post_rst", 1'b1, 5'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
